// File: rtl/seg_pkg.sv
// Shared constants and types for the seven-segment scan driver: blank pattern,
// active-low hex glyph table (segment order {g,f,e,d,c,b,a}) and scan state type.
package seg_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    localparam logic [6:0] HEX_GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef enum logic {
        BLANK = 1'b0,
        SCAN  = 1'b1
    } scan_state_t;

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational nibble to active-low seven-segment glyph lookup.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] glyph
);

    assign glyph = HEX_GLYPH[nibble];

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed seven-segment driver with a one-word pending buffer and tear-free
// frame updates. Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int DIGITS   = 8,
    parameter int SCAN_DIV = 50000,
    parameter int DEAD     = 16
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   in_data,
    input  logic [DIGITS-1:0]     in_dp,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    // Handshake: a word moves when in_valid && in_ready at a rising clk edge;
    // in_ready is a flop equal to ~pend_full, never a function of in_valid.
    scan_state_t          state, state_nxt;
    logic [CW-1:0]        cnt, cnt_nxt;
    logic [IW-1:0]        idx, idx_nxt;
    logic                 pend_full, pend_full_nxt;
    logic [4*DIGITS-1:0]  pend_data, disp_data, disp_nxt;
    logic [DIGITS-1:0]    pend_dp, disp_dp, disp_dp_nxt;
    logic                 tick, wrap, transfer, accept;
    logic [3:0]           nib;
    logic [6:0]           glyph, seg_nxt;
    logic                 dp_nxt;
    logic [DIGITS-1:0]    an_nxt;

    always_ff @(posedge clk) begin
        if (clr) state <= BLANK;
        else     state <= state_nxt;
    end

    always_comb begin
        tick          = (cnt == CW'(SCAN_DIV - 1));
        wrap          = (idx == IW'(DIGITS - 1));
        accept        = in_valid && in_ready;
        transfer      = tick && pend_full && ((state == BLANK) || wrap);
        state_nxt     = (transfer && state == BLANK) ? SCAN : state;
        cnt_nxt       = tick ? '0 : cnt + CW'(1);
        idx_nxt       = idx;
        if (state == BLANK)  idx_nxt = '0;
        else if (tick)       idx_nxt = wrap ? '0 : idx + IW'(1);
        pend_full_nxt = pend_full;
        if (accept)          pend_full_nxt = 1'b1;
        else if (transfer)   pend_full_nxt = 1'b0;
        disp_nxt      = transfer ? pend_data : disp_data;
        disp_dp_nxt   = transfer ? pend_dp : disp_dp;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt       <= '0;
            idx       <= '0;
            pend_full <= 1'b0;
            pend_data <= '0;
            pend_dp   <= '0;
            disp_data <= '0;
            disp_dp   <= '0;
        end else begin
            cnt       <= cnt_nxt;
            idx       <= idx_nxt;
            pend_full <= pend_full_nxt;
            disp_data <= disp_nxt;
            disp_dp   <= disp_dp_nxt;
            if (accept) begin
                pend_data <= in_data;
                pend_dp   <= in_dp;
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // Mask is latched with the word so the scan never re-evaluates it mid-frame.
    logic [DIGITS-1:0] blank_mask, blank_nxt, lz_mask;
    logic              seen;

    always_comb begin
        seen    = 1'b0;
        lz_mask = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            seen       = seen | (pend_data[4*i +: 4] != 4'h0);
            lz_mask[i] = ~seen;
        end
        blank_nxt = transfer ? lz_mask : blank_mask;
    end

    always_ff @(posedge clk) begin
        if (clr) blank_mask <= '0;
        else     blank_mask <= blank_nxt;
    end
`endif

    seg_hex_decode u_dec (
        .nibble (nib),
        .glyph  (glyph)
    );

    // Outputs are computed from next-cycle values so the registered bus lines up with cnt/idx.
    always_comb begin
        nib     = 4'h0;
        an_nxt  = '1;
        seg_nxt = SEG_OFF;
        dp_nxt  = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_nxt == IW'(i)) nib = disp_nxt[4*i +: 4];
        end
        if (state_nxt == SCAN && cnt_nxt >= CW'(DEAD)) begin
            seg_nxt = glyph;
            for (int i = 0; i < DIGITS; i++) begin
                if (idx_nxt == IW'(i)) begin
                    an_nxt[i] = 1'b0;
                    dp_nxt    = ~disp_dp_nxt[i];
`ifdef LEADING_ZERO_BLANK_EN
                    if (blank_nxt[i]) seg_nxt = SEG_OFF;
`endif
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            seg      <= SEG_OFF;
            dp       <= 1'b1;
            an       <= '1;
            in_ready <= 1'b1;
        end else begin
            seg      <= seg_nxt;
            dp       <= dp_nxt;
            an       <= an_nxt;
            in_ready <= ~pend_full_nxt;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with DIGITS=4, SCAN_DIV=4, DEAD=1.
module tb_seg_scan_driver;

    logic        clk = 1'b0;
    logic        clr;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [3:0]  in_dp;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    seg_scan_driver #(.DIGITS(4), .SCAN_DIV(4), .DEAD(1)) dut (
        .clk      (clk),
        .clr      (clr),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_dp    (in_dp),
        .seg      (seg),
        .dp       (dp),
        .an       (an)
    );

    always #5 clk = ~clk;

    // Invariants checked every cycle once out of the initial reset.
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if ($countones(~an) > 1) begin
                errors++;
                $display("FAIL one_hot_an: an=%b has more than one digit enabled", an);
            end
            checks++;
            if (in_ready === 1'b1 && dut.pend_full === 1'b1) begin
                errors++;
                $display("FAIL ready_vs_pending: in_ready=1 while pending buffer is full");
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_clr;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] d, input logic [3:0] p);
        bit ok;
        ok       = 1'b0;
        in_data  = d;
        in_dp    = p;
        in_valid = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL send_word: in_ready=0 for 100 cycles, required 1 for word %h", d);
        end
    endtask

    task automatic wait_digit0(input string name);
        bit found;
        found = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (an === 4'b1110) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL %s: an=%b after 40 cycles, required 1110", name, an);
        end
    endtask

    task automatic test_reset;
        clr = 1'b1; in_valid = 1'b0; in_data = '0; in_dp = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (an !== 4'hF)     begin errors++; $display("FAIL reset_an: got %b required 1111", an); end
        checks++; if (seg !== 7'h7F)   begin errors++; $display("FAIL reset_seg: got %h required 7f", seg); end
        checks++; if (dp !== 1'b1)     begin errors++; $display("FAIL reset_dp: got %b required 1", dp); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b required 1", in_ready); end
        @(posedge clk); #1;
        clr = 1'b0;
        mon_en = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checks++;
            if (an !== 4'hF || seg !== 7'h7F || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL idle_blank: an=%b seg=%h ready=%b required 1111/7f/1", an, seg, in_ready);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_scan;
        logic [6:0] exp_glyph [4];
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        logic       exp_dp;
        int         ph, d;
        exp_glyph = '{7'h0E, 7'h08, 7'h24, 7'h79};
        do_clr();
        send_word(16'h12AF, 4'b0100);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL scan_ready_low: got %b required 0", in_ready); end
        wait_digit0("scan_start");
        for (int p = 0; p < 16; p++) begin
            if (p > 0) @(negedge clk);
            ph = (p + 1) % 4;
            d  = ((p + 1) / 4) % 4;
            if (ph == 0) begin
                exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1;
            end else begin
                exp_an = ~(4'b0001 << d); exp_seg = exp_glyph[d]; exp_dp = (d == 2) ? 1'b0 : 1'b1;
            end
            checks++;
            if (an !== exp_an || seg !== exp_seg || dp !== exp_dp) begin
                errors++;
                $display("FAIL scan_frame[%0d]: an=%b seg=%h dp=%b required %b %h %b",
                         p, an, seg, dp, exp_an, exp_seg, exp_dp);
            end
        end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL scan_ready_high: got %b required 1", in_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        int         active_n, rise_n, phase;
        bit         acc;
        logic [6:0] exp_seg;
        do_clr();
        in_data = 16'h1111; in_dp = 4'h0; in_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_first_ready: got %b required 1", in_ready); end
        @(posedge clk); #1;
        in_data  = 16'h2222;
        active_n = 0; rise_n = -1; phase = 0;
        for (int c = 0; c < 80 && active_n < 24; c++) begin
            @(negedge clk);
            if (an !== 4'hF) begin
                exp_seg = (active_n < 12) ? 7'h79 : 7'h24;
                checks++;
                if (seg !== exp_seg) begin
                    errors++;
                    $display("FAIL b2b_glyph[%0d]: got %h required %h", active_n, seg, exp_seg);
                end
                active_n++;
            end
            if (phase == 1 && in_ready === 1'b1) begin
                rise_n = active_n;
                phase  = 2;
            end
            acc = (phase == 0) && (in_ready === 1'b1);
            @(posedge clk); #1;
            if (acc) begin
                in_valid = 1'b0;
                phase    = 1;
            end
        end
        in_valid = 1'b0;
        checks++;
        if (active_n != 24) begin errors++; $display("FAIL b2b_active: got %0d lit cycles required 24", active_n); end
        checks++;
        if (rise_n != 12) begin errors++; $display("FAIL b2b_ready_rise: rose after %0d lit cycles required 12", rise_n); end
    endtask

    task automatic test_clr_mid_scan;
        do_clr();
        send_word(16'h5555, 4'h0);
        send_word(16'h6666, 4'h0);
        begin : find_digit1
            bit found;
            found = 1'b0;
            for (int c = 0; c < 40; c++) begin
                @(negedge clk);
                if (an === 4'b1101) begin found = 1'b1; break; end
            end
            checks++;
            if (!found) begin errors++; $display("FAIL clr_find_digit1: an=%b required 1101", an); end
        end
        @(posedge clk); #1;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        @(negedge clk);
        checks++; if (an !== 4'hF)       begin errors++; $display("FAIL clr_an: got %b required 1111", an); end
        checks++; if (seg !== 7'h7F)     begin errors++; $display("FAIL clr_seg: got %h required 7f", seg); end
        checks++; if (dp !== 1'b1)       begin errors++; $display("FAIL clr_dp: got %b required 1", dp); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL clr_ready: got %b required 1", in_ready); end
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            checks++;
            if (an !== 4'hF) begin errors++; $display("FAIL clr_stays_blank: an=%b required 1111", an); end
        end
        @(posedge clk); #1;
        send_word(16'h0007, 4'h0);
        wait_digit0("clr_new_word");
        checks++;
        if (seg !== 7'h78) begin errors++; $display("FAIL clr_new_glyph: got %h required 78", seg); end
        @(posedge clk); #1;
    endtask

`ifdef LEADING_ZERO_BLANK_EN
    task automatic test_leading_zero;
        logic [6:0] g1 [4];
        logic [6:0] g2 [4];
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        logic       exp_dp;
        bit         found;
        int         ph, d;
        g1 = '{7'h40, 7'h30, 7'h7F, 7'h7F};
        g2 = '{7'h40, 7'h7F, 7'h7F, 7'h7F};
        do_clr();
        send_word(16'h0030, 4'b1000);
        wait_digit0("lz_start");
        for (int p = 0; p < 16; p++) begin
            if (p > 0) @(negedge clk);
            ph = (p + 1) % 4;
            d  = ((p + 1) / 4) % 4;
            if (ph == 0) begin
                exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1;
            end else begin
                exp_an = ~(4'b0001 << d); exp_seg = g1[d]; exp_dp = (d == 3) ? 1'b0 : 1'b1;
            end
            checks++;
            if (an !== exp_an || seg !== exp_seg || dp !== exp_dp) begin
                errors++;
                $display("FAIL lz_0030[%0d]: an=%b seg=%h dp=%b required %b %h %b",
                         p, an, seg, dp, exp_an, exp_seg, exp_dp);
            end
        end
        @(posedge clk); #1;
        send_word(16'h0000, 4'b0000);
        found = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin found = 1'b1; break; end
        end
        checks++;
        if (!found) begin errors++; $display("FAIL lz_transfer: in_ready=0 after 40 cycles required 1"); end
        wait_digit0("lz_zero_start");
        for (int p = 0; p < 16; p++) begin
            if (p > 0) @(negedge clk);
            ph = (p + 1) % 4;
            d  = ((p + 1) / 4) % 4;
            if (ph == 0) begin
                exp_an = 4'hF; exp_seg = 7'h7F;
            end else begin
                exp_an = ~(4'b0001 << d); exp_seg = g2[d];
            end
            checks++;
            if (an !== exp_an || seg !== exp_seg || dp !== 1'b1) begin
                errors++;
                $display("FAIL lz_0000[%0d]: an=%b seg=%h dp=%b required %b %h 1",
                         p, an, seg, dp, exp_an, exp_seg);
            end
        end
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        test_reset();
        test_scan();
        test_back_to_back();
        test_clr_mid_scan();
`ifdef LEADING_ZERO_BLANK_EN
        test_leading_zero();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
